uart_csr_bank: RTL and testbench

//  Parametrised UART control/status register bank between the processor load/store port and the UART TX/RX FIFOs.

---
 rtl/uart_csr_bank.sv | 183 ++++++++++++++++++
 tb/tb_uart_csr_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_bank.sv
// UART control/status register bank: bus-mapped CTRL/BAUD/IER/ISR/RXTHR registers,
// sticky error capture, RX-threshold interrupt and single-cycle TX push / RX pop strobes.
module uart_csr_bank #(
    parameter int DATA_W     = 8,
    parameter int BAUD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic              bus_re,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              irq,
    output logic              tx_push,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_full,
    input  logic [LVL_W-1:0]  tx_level,
    output logic              rx_pop,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_empty,
    input  logic [LVL_W-1:0]  rx_level,
    input  logic              par_err_p,
    input  logic              stop_err_p,
    input  logic              rx_ovr_p,
    input  logic              busy,
    output logic [7:0]        ctrl_o,
    output logic [BAUD_W-1:0] baud_div
);

    typedef enum logic [ADDR_W-1:0] {
        REG_DATA   = ADDR_W'(0),
        REG_CTRL   = ADDR_W'(1),
        REG_STATUS = ADDR_W'(2),
        REG_BAUD   = ADDR_W'(3),
        REG_IER    = ADDR_W'(4),
        REG_ISR    = ADDR_W'(5),
        REG_LEVEL  = ADDR_W'(6),
        REG_RXTHR  = ADDR_W'(7)
    } reg_addr_e;

    localparam int ISR_PAR_ERR  = 0;
    localparam int ISR_STOP_ERR = 1;
    localparam int ISR_RX_OVR   = 2;
    localparam int ISR_TX_OVF   = 3;
    localparam int ISR_RX_UNF   = 4;
    localparam int ISR_CFG_ERR  = 5;
    localparam int CTRL_UART_EN = 4;

    logic              wr_acc;
    logic              rd_acc;
    logic [7:0]        ier_q;
    logic [5:0]        sticky_q;
    logic [LVL_W-1:0]  rxthr_q;
    logic [5:0]        sticky_set;
    logic [5:0]        sticky_clr;
    logic              rx_thr_live;
    logic              tx_empty_live;
    logic [7:0]        isr_view;
    logic [31:0]       rd_mux;
    logic [LVL_W-1:0]  rxthr_wval;
    logic              ctrl_wr_ok;
    logic              baud_wr_ok;

    // Write has priority over read when both strobes are raised.
    assign wr_acc = bus_sel && bus_we;
    assign rd_acc = bus_sel && bus_re && !bus_we;

    assign rx_thr_live   = (rx_level >= rxthr_q);
    assign tx_empty_live = (tx_level == '0);
    assign isr_view      = {tx_empty_live, rx_thr_live, sticky_q};

    assign ctrl_wr_ok = !busy;
    assign baud_wr_ok = !busy && !ctrl_o[CTRL_UART_EN];

    always_comb begin
        sticky_set               = '0;
        sticky_set[ISR_PAR_ERR]  = par_err_p;
        sticky_set[ISR_STOP_ERR] = stop_err_p;
        sticky_set[ISR_RX_OVR]   = rx_ovr_p;
        sticky_clr               = '0;
        if (wr_acc) begin
            case (bus_addr)
                REG_DATA: sticky_set[ISR_TX_OVF]  = tx_full;
                REG_CTRL: sticky_set[ISR_CFG_ERR] = !ctrl_wr_ok;
                REG_BAUD: sticky_set[ISR_CFG_ERR] = !baud_wr_ok;
                REG_ISR:  sticky_clr              = bus_wdata[5:0];
                default:  ;
            endcase
        end
        if (rd_acc && bus_addr == REG_DATA) begin
            sticky_set[ISR_RX_UNF] = rx_empty;
        end
    end

    // Threshold 0 would make the interrupt permanently true, so it is coerced to 1.
    always_comb begin
        if (bus_wdata == '0) begin
            rxthr_wval = LVL_W'(1);
        end else if (bus_wdata > 32'(FIFO_DEPTH)) begin
            rxthr_wval = LVL_W'(FIFO_DEPTH);
        end else begin
            rxthr_wval = bus_wdata[LVL_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            REG_DATA:   rd_mux = rx_empty ? '0 : 32'(rx_data);
            REG_CTRL:   rd_mux = 32'(ctrl_o);
            REG_STATUS: rd_mux = 32'({busy, rx_thr_live, tx_empty_live, rx_empty, tx_full});
            REG_BAUD:   rd_mux = 32'(baud_div);
            REG_IER:    rd_mux = 32'(ier_q);
            REG_ISR:    rd_mux = 32'(isr_view);
            REG_LEVEL: begin
                rd_mux[23:16] = 8'(rx_level);
                rd_mux[7:0]   = 8'(tx_level);
            end
            REG_RXTHR:  rd_mux = 32'(rxthr_q);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata <= '0;
            rx_pop    <= 1'b0;
        end else begin
            rx_pop <= 1'b0;
            if (rd_acc) begin
                bus_rdata <= rd_mux;
                rx_pop    <= (bus_addr == REG_DATA) && !rx_empty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_push <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_push <= 1'b0;
            if (wr_acc && bus_addr == REG_DATA && !tx_full) begin
                tx_data <= bus_wdata[DATA_W-1:0];
                tx_push <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_o   <= '0;
            baud_div <= '0;
            ier_q    <= '0;
            rxthr_q  <= LVL_W'(1);
        end else if (wr_acc) begin
            case (bus_addr)
                REG_CTRL: if (ctrl_wr_ok) ctrl_o <= {bus_wdata[7:2], 2'b00};
                REG_BAUD: if (baud_wr_ok) baud_div <= bus_wdata[BAUD_W-1:0];
                REG_IER:  ier_q <= bus_wdata[7:0];
                REG_RXTHR: rxthr_q <= rxthr_wval;
                default:  ;
            endcase
        end
    end

    // A new event in the same cycle as its W1C clear must survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
            irq      <= 1'b0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
            irq      <= |(isr_view & ier_q);
        end
    end

endmodule

// File: tb/tb_uart_csr_bank.sv
// Self-checking bench for uart_csr_bank: directed scenarios followed by random
// bus/FIFO/error traffic, compared every cycle against a register-map reference model.
module tb_uart_csr_bank;

    localparam int DATA_W     = 8;
    localparam int BAUD_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              bus_sel;
    logic              bus_we;
    logic              bus_re;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              irq;
    logic              tx_push;
    logic [DATA_W-1:0] tx_data;
    logic              tx_full;
    logic [LVL_W-1:0]  tx_level;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic [LVL_W-1:0]  rx_level;
    logic              par_err_p;
    logic              stop_err_p;
    logic              rx_ovr_p;
    logic              busy;
    logic [7:0]        ctrl_o;
    logic [BAUD_W-1:0] baud_div;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_csr_bank #(
        .DATA_W     (DATA_W),
        .BAUD_W     (BAUD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_sel    (bus_sel),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .irq        (irq),
        .tx_push    (tx_push),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_level   (tx_level),
        .rx_pop     (rx_pop),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_level   (rx_level),
        .par_err_p  (par_err_p),
        .stop_err_p (stop_err_p),
        .rx_ovr_p   (rx_ovr_p),
        .busy       (busy),
        .ctrl_o     (ctrl_o),
        .baud_div   (baud_div)
    );

    // Reference model state: architectural register contents and expected outputs.
    logic [7:0]  m_ctrl   = '0;
    logic [15:0] m_baud   = '0;
    logic [7:0]  m_ier    = '0;
    logic [5:0]  m_sticky = '0;
    int          m_rxthr  = 1;
    logic [31:0] m_rdata  = '0;
    logic        m_irq    = 1'b0;
    logic        m_push   = 1'b0;
    logic        m_pop    = 1'b0;
    logic [7:0]  m_txdata = '0;

    function automatic logic [7:0] m_isr();
        return {tx_level == 0, int'(rx_level) >= m_rxthr, m_sticky};
    endfunction

    function automatic logic [31:0] m_reg(input int a);
        case (a)
            1: return {24'h0, m_ctrl};
            2: return {27'h0, busy, int'(rx_level) >= m_rxthr, tx_level == 0, rx_empty, tx_full};
            3: return {16'h0, m_baud};
            4: return {24'h0, m_ier};
            5: return {24'h0, m_isr()};
            6: return {8'h0, 3'b0, rx_level, 8'h0, 3'b0, tx_level};
            7: return 32'(m_rxthr);
            default: return 32'h0;
        endcase
    endfunction

    // Applies one clock edge worth of register-map semantics to the model.
    task automatic model_edge();
        logic [5:0] set_b;
        logic [5:0] clr_b;
        int         a;
        if (reset) begin
            m_ctrl = '0; m_baud = '0; m_ier = '0; m_sticky = '0; m_rxthr = 1;
            m_rdata = '0; m_irq = 1'b0; m_push = 1'b0; m_pop = 1'b0; m_txdata = '0;
            return;
        end
        a      = int'(bus_addr);
        m_irq  = |(m_isr() & m_ier);
        m_push = 1'b0;
        m_pop  = 1'b0;
        set_b  = {3'b000, rx_ovr_p, stop_err_p, par_err_p};
        clr_b  = '0;
        if (bus_sel && bus_we) begin
            case (a)
                0: if (tx_full) set_b[3] = 1'b1;
                   else begin m_txdata = bus_wdata[7:0]; m_push = 1'b1; end
                1: if (busy) set_b[5] = 1'b1;
                   else m_ctrl = {bus_wdata[7:2], 2'b00};
                3: if (busy || m_ctrl[4]) set_b[5] = 1'b1;
                   else m_baud = bus_wdata[15:0];
                4: m_ier = bus_wdata[7:0];
                5: clr_b = bus_wdata[5:0];
                7: m_rxthr = (bus_wdata == 0) ? 1 :
                             (bus_wdata > 32'(FIFO_DEPTH)) ? FIFO_DEPTH : int'(bus_wdata);
                default: ;
            endcase
        end else if (bus_sel && bus_re) begin
            if (a == 0) begin
                if (rx_empty) begin m_rdata = 0; set_b[4] = 1'b1; end
                else begin m_rdata = 32'(rx_data); m_pop = 1'b1; end
            end else begin
                m_rdata = m_reg(a);
            end
        end
        m_sticky = (m_sticky & ~clr_b) | set_b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("rdata",    bus_rdata,       m_rdata);
        chk("irq",      32'(irq),        32'(m_irq));
        chk("tx_push",  32'(tx_push),    32'(m_push));
        chk("rx_pop",   32'(rx_pop),     32'(m_pop));
        chk("tx_data",  32'(tx_data),    32'(m_txdata));
        chk("ctrl_o",   32'(ctrl_o),     32'(m_ctrl));
        chk("baud_div", 32'(baud_div),   32'(m_baud));
    endtask

    task automatic idle();
        bus_sel = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        par_err_p = 1'b0; stop_err_p = 1'b0; rx_ovr_p = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus_sel = 1'b1; bus_we = 1'b1; bus_re = 1'b0;
        bus_addr = ADDR_W'(a); bus_wdata = d;
        tick();
        idle();
    endtask

    task automatic rd(input int a);
        bus_sel = 1'b1; bus_we = 1'b0; bus_re = 1'b1;
        bus_addr = ADDR_W'(a);
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1; bus_addr = '0; bus_wdata = '0;
        tx_full = 1'b0; tx_level = 5'd3; rx_data = '0; rx_empty = 1'b1; rx_level = '0; busy = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        for (int a = 1; a < 8; a++) rd(a);
        rd(0);
        rd(5);
        wr(5, 32'h3F);

        wr(0, 32'h41);
        tick();
        tx_full = 1'b1;
        wr(0, 32'h42);
        rd(5);
        wr(5, 32'h08);
        tx_full = 1'b0;

        rx_data = 8'h5A; rx_empty = 1'b0;
        rd(0);
        tick();
        rx_empty = 1'b1;
        rd(0);
        rd(5);
        rx_empty = 1'b0; rx_data = 8'hC3;
        bus_sel = 1'b1; bus_re = 1'b1; bus_addr = '0;
        tick();
        rx_data = 8'h17;
        tick();
        idle();
        tick();
        wr(5, 32'h3F);

        wr(4, 32'h01);
        par_err_p = 1'b1;
        tick();
        idle();
        tick();
        tick();
        par_err_p = 1'b1;
        wr(5, 32'h01);
        rd(5);
        wr(5, 32'h3F);
        wr(4, 32'h00);

        wr(7, 32'd4);
        rx_level = 5'd3;
        wr(4, 32'h40);
        rx_level = 5'd4;
        tick();
        tick();
        rx_level = 5'd3;
        tick();
        tick();
        wr(7, 32'd0);
        rd(7);
        wr(7, 32'd100);
        rd(7);
        wr(4, 32'h00);

        busy = 1'b1;
        wr(1, 32'hFF);
        rd(5);
        busy = 1'b0;
        wr(1, 32'h10);
        wr(3, 32'h1234);
        rd(5);
        wr(1, 32'h00);
        wr(3, 32'h1234);
        rd(3);
        rd(12);

        // Reset asserted alongside an accepted DATA write must suppress the push.
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = '0; bus_wdata = 32'h55; reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        tick();

        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            bus_sel    = ($urandom_range(0, 3) != 0);
            bus_we     = 1'($urandom_range(0, 1));
            bus_re     = 1'($urandom_range(0, 1));
            bus_addr   = ADDR_W'($urandom_range(0, 9));
            bus_wdata  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            tx_full    = 1'($urandom_range(0, 1));
            rx_empty   = 1'($urandom_range(0, 1));
            tx_level   = LVL_W'($urandom_range(0, FIFO_DEPTH));
            rx_level   = LVL_W'($urandom_range(0, FIFO_DEPTH));
            rx_data    = DATA_W'($urandom);
            par_err_p  = ($urandom_range(0, 15) == 0);
            stop_err_p = ($urandom_range(0, 15) == 0);
            rx_ovr_p   = ($urandom_range(0, 15) == 0);
            busy       = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
